// File: rtl/div_issue_ctrl.sv
// Front-end controller for the iterative divider: decodes RV32M divide ops, short-circuits
// special cases and repeated operands, and sequences the core for everything else.
module div_issue_ctrl #(
    parameter int DW       = 32,
    parameter int WAIT_MAX = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic [1:0]    req_op_i,
    input  logic [DW-1:0] req_a_i,
    input  logic [DW-1:0] req_b_i,
    input  logic [4:0]    req_rd_i,
    input  logic          flush_i,
    output logic          req_ready_o,
    output logic          stall_o,
    output logic          div_en_o,
    output logic [DW-1:0] div_dividend_o,
    output logic [DW-1:0] div_divisor_o,
    output logic          div_signed_o,
    input  logic [DW-1:0] div_quot_i,
    input  logic [DW-1:0] div_rem_i,
    input  logic          div_done_i,
    output logic          wb_valid_o,
    output logic [4:0]    wb_rd_o,
    output logic [DW-1:0] wb_data_o,
    output logic          err_o
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam int            CW      = $clog2(WAIT_MAX + 1);
    localparam logic [DW-1:0] INT_MIN = {1'b1, {(DW-1){1'b0}}};

    state_t        state_q, state_d;
    logic          sel_rem_q, signed_q, kill_q;
    logic [DW-1:0] a_q, b_q, res_q;
    logic [4:0]    rd_q;
    logic [CW-1:0] cnt_q;

    logic          cache_vld_q, cache_s_q;
    logic [DW-1:0] cache_a_q, cache_b_q, cache_quot_q, cache_rem_q;

    logic          req_signed, accept, div_zero, overflow, hit, fast, timeout, done_wait;
    logic [DW-1:0] fast_data;

    always_comb begin
        req_signed = ~req_op_i[0];
        accept     = (state_q == IDLE) && req_valid_i && !flush_i;
        div_zero   = (req_b_i == '0);
        overflow   = req_signed && (req_a_i == INT_MIN) && (req_b_i == '1);
        hit        = cache_vld_q && (cache_a_q == req_a_i) && (cache_b_q == req_b_i)
                     && (cache_s_q == req_signed);
        fast       = div_zero || overflow || hit;
        // Special cases take priority; a cache entry can never hold them anyway.
        if (div_zero) begin
            fast_data = req_op_i[1] ? req_a_i : '1;
        end else if (overflow) begin
            fast_data = req_op_i[1] ? '0 : req_a_i;
        end else begin
            fast_data = req_op_i[1] ? cache_rem_q : cache_quot_q;
        end
        done_wait = (state_q == WAIT) && div_done_i;
        timeout   = (state_q == WAIT) && !div_done_i && (cnt_q == CW'(WAIT_MAX - 1));
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = fast ? RESP : ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT: begin
                if (div_done_i)   state_d = (kill_q || flush_i) ? IDLE : RESP;
                else if (timeout) state_d = IDLE;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_rem_q   <= 1'b0;
            signed_q    <= 1'b0;
            kill_q      <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            rd_q        <= '0;
            res_q       <= '0;
            cnt_q       <= '0;
            cache_vld_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                sel_rem_q <= req_op_i[1];
                signed_q  <= req_signed;
                a_q       <= req_a_i;
                b_q       <= req_b_i;
                rd_q      <= req_rd_i;
                res_q     <= fast_data;
                kill_q    <= 1'b0;
                cnt_q     <= '0;
            end
            // The core cannot abort, so a flush only marks the op to be discarded.
            if ((state_q == ISSUE || state_q == WAIT) && flush_i) kill_q <= 1'b1;
            if (state_q == WAIT) cnt_q <= cnt_q + 1'b1;
            if (done_wait) begin
                res_q       <= sel_rem_q ? div_rem_i : div_quot_i;
                cache_vld_q <= 1'b1;
            end else if (timeout) begin
                cache_vld_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (done_wait) begin
            cache_a_q    <= a_q;
            cache_b_q    <= b_q;
            cache_s_q    <= signed_q;
            cache_quot_q <= div_quot_i;
            cache_rem_q  <= div_rem_i;
        end
    end

    assign req_ready_o    = (state_q == IDLE);
    assign stall_o        = accept || (state_q == ISSUE) || (state_q == WAIT);
    assign div_en_o       = (state_q == ISSUE);
    assign div_dividend_o = a_q;
    assign div_divisor_o  = b_q;
    assign div_signed_o   = signed_q;
    assign wb_valid_o     = (state_q == RESP) && !flush_i;
    assign wb_rd_o        = rd_q;
    assign wb_data_o      = res_q;
    assign err_o          = timeout;
endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed spec cases plus random ops against an arithmetic reference.
module tb_div_issue_ctrl;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst, req_valid_i, flush_i, div_done_i;
    logic [1:0]    req_op_i;
    logic [DW-1:0] req_a_i, req_b_i, div_quot_i, div_rem_i;
    logic [4:0]    req_rd_i;
    logic          req_ready_o, stall_o, div_en_o, div_signed_o, wb_valid_o, err_o;
    logic [DW-1:0] div_dividend_o, div_divisor_o, wb_data_o;
    logic [4:0]    wb_rd_o;

    div_issue_ctrl #(.DW(DW), .WAIT_MAX(64)) dut (
        .clk(clk), .rst(rst), .req_valid_i(req_valid_i), .req_op_i(req_op_i),
        .req_a_i(req_a_i), .req_b_i(req_b_i), .req_rd_i(req_rd_i), .flush_i(flush_i),
        .req_ready_o(req_ready_o), .stall_o(stall_o), .div_en_o(div_en_o),
        .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o),
        .div_signed_o(div_signed_o), .div_quot_i(div_quot_i), .div_rem_i(div_rem_i),
        .div_done_i(div_done_i), .wb_valid_o(wb_valid_o), .wb_rd_o(wb_rd_o),
        .wb_data_o(wb_data_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int en_cnt = 0;
    always @(posedge clk) if (div_en_o === 1'b1) en_cnt <= en_cnt + 1;

    // Reference cache: which operand set the core last completed.
    logic          mc_vld = 1'b0;
    logic          mc_s;
    logic [DW-1:0] mc_a, mc_b;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    function automatic logic [DW-1:0] ref_res(input logic [1:0] op, input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
        logic          s;
        logic [DW-1:0] q, r;
        s = ~op[0];
        if (b == 0) begin
            q = '1; r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = a; r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return op[1] ? r : q;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, 64'(req_ready_o), 64'd1);
        check({tag, "_stall"}, 64'(stall_o), 64'd0);
        check({tag, "_en"}, 64'(div_en_o), 64'd0);
        check({tag, "_wbv"}, 64'(wb_valid_o), 64'd0);
        check({tag, "_wbd"}, 64'(wb_data_o), 64'd0);
        check({tag, "_wbrd"}, 64'(wb_rd_o), 64'd0);
        check({tag, "_err"}, 64'(err_o), 64'd0);
        check({tag, "_opnd"}, {div_dividend_o, div_divisor_o}, 64'd0);
        check({tag, "_sgn"}, 64'(div_signed_o), 64'd0);
    endtask

    // One request; the bench plays the divider core when the op must go to it.
    task automatic do_op(input logic [1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [4:0] rd, input int delay, input bit flush_wait,
                         output logic [DW-1:0] got);
        logic s, fast, ds;
        logic [DW-1:0] da, db, q, r;
        int en0;
        s    = ~op[0];
        fast = (b == 0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
               || (mc_vld && mc_a == a && mc_b == b && mc_s == s);
        en0  = en_cnt;
        got  = '0;
        tick();
        req_valid_i = 1'b1; req_op_i = op; req_a_i = a; req_b_i = b; req_rd_i = rd;
        smp();
        check("ready_acc", 64'(req_ready_o), 64'd1);
        check("stall_acc", 64'(stall_o), 64'd1);
        tick();
        req_valid_i = 1'b0; req_a_i = $urandom; req_b_i = $urandom; req_rd_i = 5'($urandom);
        smp();
        if (fast) begin
            check("wb_fast", 64'(wb_valid_o), 64'd1);
            check("rd_fast", 64'(wb_rd_o), 64'(rd));
            check("stall_resp", 64'(stall_o), 64'd0);
            got = wb_data_o;
        end else begin
            check("en_issue", 64'(div_en_o), 64'd1);
            da = div_dividend_o; db = div_divisor_o; ds = div_signed_o;
            check("opnd_issue", {da, db}, {a, b});
            check("sgn_issue", 64'(ds), 64'(s));
            tick();
            if (flush_wait) flush_i = 1'b1;
            smp();
            check("stall_wait", 64'(stall_o), 64'd1);
            tick();
            flush_i = 1'b0;
            repeat (delay) tick();
            if (db == 0) begin
                q = '1; r = da;
            end else if (ds) begin
                q = $signed(da) / $signed(db); r = $signed(da) % $signed(db);
            end else begin
                q = da / db; r = da % db;
            end
            div_done_i = 1'b1; div_quot_i = q; div_rem_i = r;
            tick();
            div_done_i = 1'b0; div_quot_i = $urandom; div_rem_i = $urandom;
            smp();
            mc_vld = 1'b1; mc_a = a; mc_b = b; mc_s = s;
            if (flush_wait) begin
                check("wb_killed", 64'(wb_valid_o), 64'd0);
                check("ready_kill", 64'(req_ready_o), 64'd1);
            end else begin
                check("wb_core", 64'(wb_valid_o), 64'd1);
                check("rd_core", 64'(wb_rd_o), 64'(rd));
                got = wb_data_o;
            end
        end
        if (fast || !flush_wait) check("wb_data", 64'(got), 64'(ref_res(op, a, b)));
        tick();
        smp();
        check("wb_once", 64'(wb_valid_o), 64'd0);
        check("ready_back", 64'(req_ready_o), 64'd1);
        check("en_count", 64'(en_cnt - en0), fast ? 64'd0 : 64'd1);
    endtask

    initial begin
        logic [DW-1:0] got, ra, rb;
        logic [1:0]    rop;
        int            k, en0;
        rst = 1'b1; req_valid_i = 1'b0; flush_i = 1'b0; div_done_i = 1'b0;
        req_op_i = 2'b00; req_a_i = '0; req_b_i = '0; req_rd_i = '0;
        div_quot_i = '0; div_rem_i = '0;
        repeat (2) tick();
        smp();
        check_reset_outputs("rst0");
        tick();
        rst = 1'b0;

        do_op(2'b00, 32'd20, 32'hFFFF_FFFD, 5'd5, 3, 1'b0, got);
        check("div_20_m3", 64'(got), 64'hFFFF_FFFA);
        do_op(2'b10, 32'd20, 32'hFFFF_FFFD, 5'd6, 0, 1'b0, got);
        check("rem_20_m3_hit", 64'(got), 64'd2);
        do_op(2'b01, 32'd7, 32'd0, 5'd7, 0, 1'b0, got);
        check("divu_7_0", 64'(got), 64'hFFFF_FFFF);
        do_op(2'b11, 32'd7, 32'd0, 5'd8, 0, 1'b0, got);
        check("remu_7_0", 64'(got), 64'd7);
        do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 0, 1'b0, got);
        check("div_ovf", 64'(got), 64'h8000_0000);
        do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0, 1'b0, got);
        check("rem_ovf", 64'(got), 64'd0);
        do_op(2'b01, 32'd100, 32'd7, 5'd11, 2, 1'b0, got);
        check("divu_100_7", 64'(got), 64'd14);
        do_op(2'b11, 32'd100, 32'd7, 5'd12, 0, 1'b0, got);
        check("remu_100_7_hit", 64'(got), 64'd2);
        do_op(2'b00, 32'd100, 32'd7, 5'd13, 1, 1'b0, got);
        check("div_100_7_miss", 64'(got), 64'd14);

        // Killed op still fills the cache.
        do_op(2'b00, 32'd50, 32'd3, 5'd14, 4, 1'b1, got);
        do_op(2'b10, 32'd50, 32'd3, 5'd15, 0, 1'b0, got);
        check("rem_after_kill", 64'(got), 64'd2);

        // Request coinciding with flush is dropped.
        en0 = en_cnt;
        tick();
        req_valid_i = 1'b1; flush_i = 1'b1; req_op_i = 2'b01; req_a_i = 32'd9; req_b_i = 32'd2;
        smp();
        check("drop_stall", 64'(stall_o), 64'd0);
        tick();
        req_valid_i = 1'b0; flush_i = 1'b0;
        smp();
        check("drop_wb", 64'(wb_valid_o), 64'd0);
        check("drop_ready", 64'(req_ready_o), 64'd1);
        tick();
        smp();
        check("drop_en", 64'(en_cnt - en0), 64'd0);

        // Timeout invalidates the cache.
        do_op(2'b01, 32'd123456, 32'd789, 5'd16, 0, 1'b0, got);
        tick();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_a_i = 32'd999; req_b_i = 32'd5;
        tick();
        req_valid_i = 1'b0;
        smp();
        check("to_issue", 64'(div_en_o), 64'd1);
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            smp();
            if (wb_valid_o === 1'b1) check("to_no_wb", 64'(wb_valid_o), 64'd0);
            if (err_o === 1'b1) begin
                k = i;
                break;
            end
        end
        check("to_cycle", 64'(k), 64'd64);
        tick();
        smp();
        check("to_err_pulse", 64'(err_o), 64'd0);
        check("to_ready", 64'(req_ready_o), 64'd1);
        check("to_wb", 64'(wb_valid_o), 64'd0);
        mc_vld = 1'b0;
        do_op(2'b11, 32'd123456, 32'd789, 5'd17, 1, 1'b0, got);
        check("remu_after_to", 64'(got), 64'd372);

        // Reset during WAIT drops the op and the cache.
        do_op(2'b00, 32'd1000, 32'hFFFF_FFF9, 5'd18, 0, 1'b0, got);
        tick();
        req_valid_i = 1'b1; req_op_i = 2'b01; req_a_i = 32'd77; req_b_i = 32'd3; req_rd_i = 5'd19;
        tick();
        req_valid_i = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        smp();
        check_reset_outputs("rst_wait");
        mc_vld = 1'b0;
        tick();
        div_done_i = 1'b1; div_quot_i = 32'h1234; div_rem_i = 32'h5678;
        smp();
        check("done_idle_ready", 64'(req_ready_o), 64'd1);
        tick();
        div_done_i = 1'b0;
        smp();
        check("done_idle_wb", 64'(wb_valid_o), 64'd0);
        do_op(2'b10, 32'd1000, 32'hFFFF_FFF9, 5'd20, 2, 1'b0, got);
        check("rem_after_rst", 64'(got), 64'd6);

        // Random traffic.
        ra = 32'd1; rb = 32'd1;
        for (int n = 0; n < 60; n++) begin
            rop = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 9))
                0:       rb = '0;
                1:       begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2, 3:    ;
                4:       begin ra = $urandom; rb = $urandom_range(1, 20); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            do_op(rop, ra, rb, 5'($urandom), $urandom_range(0, 6), ($urandom_range(0, 7) == 0), got);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
